// File: rtl/branch_metric.sv
//=== branch_metric | Radix-4 hard-decision Hamming branch metrics, 2-stage pipe, block counting ===
//=== Rev 1.0 ===
`default_nettype none

module branch_metric #(
  parameter int BLK_PAIRS = 8,
  localparam int SLICED_INPUT_NUM = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en_bm,
  input  logic                        i_code_rate,
  input  logic [SLICED_INPUT_NUM-1:0] i_rx,
  input  logic                        i_valid,
  input  logic                        i_ood,
  output logic [15:0]                 o_bm_0,
  output logic [15:0]                 o_bm_1,
  output logic                        o_valid,
  output logic                        o_blk_done,
  output logic [7:0]                  o_pair_cnt,
  output logic                        o_ood
);

  localparam logic [7:0] c_blk_pairs   = 8'(BLK_PAIRS);
  localparam logic       c_code_rate_3 = 1'b1;

  // Rate 1/2 only uses the two low bits; codewords 4..7 do not exist there.
  function automatic logic [1:0] f_dist(input logic [2:0] sym, input logic [2:0] cw, input logic rate);
    logic [2:0] w_x;
    logic [1:0] w_d;
    w_x = (sym ^ cw) & ((rate == c_code_rate_3) ? 3'b111 : 3'b011);
    w_d = {1'b0, w_x[0]} + {1'b0, w_x[1]} + {1'b0, w_x[2]};
    if ((rate != c_code_rate_3) && cw[2]) w_d = 2'd0;
    return w_d;
  endfunction

  logic [SLICED_INPUT_NUM-1:0] r_s1_rx;
  logic                        r_s1_rate;
  logic                        r_s1_valid;
  logic                        r_s1_ood;

  logic [15:0] r_bm_0;
  logic [15:0] r_bm_1;
  logic        r_valid;
  logic        r_blk_done;
  logic [7:0]  r_pair_cnt;
  logic        r_ood;

  logic [15:0] w_bm_0;
  logic [15:0] w_bm_1;
  logic        w_v;
  logic [7:0]  w_cnt_inc;
  logic        w_full;
  logic        w_flush;
  logic        w_done;
  logic [7:0]  w_cnt_next;

  for (genvar c = 0; c < 8; c++) begin : g_cw
    assign w_bm_0[2*c +: 2] = f_dist(r_s1_rx[2:0], 3'(c), r_s1_rate);
    assign w_bm_1[2*c +: 2] = f_dist(r_s1_rx[5:3], 3'(c), r_s1_rate);
  end

  // Pairs arriving after end-of-data was reported are dropped.
  assign w_v        = r_s1_valid & ~r_ood;
  assign w_cnt_inc  = r_pair_cnt + {7'd0, w_v};
  assign w_full     = w_v && (w_cnt_inc == c_blk_pairs);
  assign w_flush    = r_s1_ood && (w_cnt_inc != 8'd0);
  assign w_done     = w_full | w_flush;
  assign w_cnt_next = w_done ? 8'd0 : w_cnt_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_rx    <= '0;
      r_s1_rate  <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_ood   <= 1'b0;
      r_bm_0     <= '0;
      r_bm_1     <= '0;
      r_valid    <= 1'b0;
      r_blk_done <= 1'b0;
      r_pair_cnt <= '0;
      r_ood      <= 1'b0;
    end else if (en_bm) begin
      r_s1_rx    <= i_rx;
      r_s1_rate  <= i_code_rate;
      r_s1_valid <= i_valid;
      r_s1_ood   <= i_ood;
      r_bm_0     <= w_v ? w_bm_0 : 16'd0;
      r_bm_1     <= w_v ? w_bm_1 : 16'd0;
      r_valid    <= w_v;
      r_blk_done <= w_done;
      r_pair_cnt <= w_cnt_next;
      r_ood      <= r_ood | r_s1_ood;
    end
  end

  assign o_bm_0     = r_bm_0;
  assign o_bm_1     = r_bm_1;
  assign o_valid    = r_valid;
  assign o_blk_done = r_blk_done;
  assign o_pair_cnt = r_pair_cnt;
  assign o_ood      = r_ood;

endmodule

`default_nettype wire

// File: tb/tb_branch_metric.sv
//=== tb_branch_metric | Randomized + directed bench for branch_metric against a behavioural model ===
//=== Rev 1.0 ===
`default_nettype none

module tb_branch_metric;

  localparam int BLK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_bm = 1'b1;
  logic        code_rate = 1'b0;
  logic [5:0]  rx = '0;
  logic        valid = 1'b0;
  logic        ood = 1'b0;
  logic [15:0] bm_0, bm_1;
  logic        o_valid, blk_done, o_ood;
  logic [7:0]  pair_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int seen_valid = 0;
  int seen_done = 0;

  // Reference state: last accepted input pair plus the expected outputs.
  logic        m_in_rate, m_in_valid, m_in_ood;
  logic [5:0]  m_in_rx;
  logic [15:0] m_bm0, m_bm1;
  logic        m_valid, m_done, m_ood;
  int          m_cnt;

  branch_metric #(.BLK_PAIRS(BLK)) dut (
    .clk(clk), .rst(rst), .en_bm(en_bm), .i_code_rate(code_rate), .i_rx(rx),
    .i_valid(valid), .i_ood(ood), .o_bm_0(bm_0), .o_bm_1(bm_1), .o_valid(o_valid),
    .o_blk_done(blk_done), .o_pair_cnt(pair_cnt), .o_ood(o_ood)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ref_bm(input logic [2:0] sym, input logic rate);
    logic [15:0] r;
    logic [2:0]  cw;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      cw = 3'(c);
      if (rate || c < 4) r[2*c +: 2] = 2'($countones((sym ^ cw) & (rate ? 3'b111 : 3'b011)));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    {m_in_rate, m_in_valid, m_in_ood, m_in_rx} = '0;
    m_bm0 = '0; m_bm1 = '0; m_valid = 0; m_done = 0; m_ood = 0; m_cnt = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".bm0"},  bm_0, m_bm0);
    chk({tag, ".bm1"},  bm_1, m_bm1);
    chk({tag, ".valid"}, 16'(o_valid), 16'(m_valid));
    chk({tag, ".done"},  16'(blk_done), 16'(m_done));
    chk({tag, ".cnt"},   16'(pair_cnt), 16'(m_cnt));
    chk({tag, ".ood"},   16'(o_ood), 16'(m_ood));
  endtask

  task automatic drive(input logic e, input logic r, input logic [5:0] x, input logic v, input logic d);
    en_bm = e; code_rate = r; rx = x; valid = v; ood = d;
  endtask

  // One clock edge: advance the model with the inputs that edge sampled, then compare.
  task automatic tick(input string tag);
    logic e_en, e_rst, acc;
    int   nc;
    e_en = en_bm; e_rst = rst;
    @(posedge clk); #1;
    if (!e_rst) model_zero();
    else if (e_en) begin
      acc     = m_in_valid && !m_ood;
      m_bm0   = acc ? ref_bm(m_in_rx[2:0], m_in_rate) : 16'd0;
      m_bm1   = acc ? ref_bm(m_in_rx[5:3], m_in_rate) : 16'd0;
      m_valid = acc;
      nc      = m_cnt + (acc ? 1 : 0);
      m_done  = (acc && nc == BLK) || (m_in_ood && nc % BLK != 0);
      m_cnt   = m_done ? 0 : nc;
      m_ood   = m_ood | m_in_ood;
      {m_in_rate, m_in_rx, m_in_valid, m_in_ood} = {code_rate, rx, valid, ood};
      if (o_valid) seen_valid++;
      if (blk_done) seen_done++;
    end
    chk_all(tag);
  endtask

  task automatic do_reset();
    rst = 1'b0; #1;
    model_zero();
    chk_all("async_rst");
    tick("rst_hold");
    rst = 1'b1;
  endtask

  initial begin
    model_zero();
    drive(1, 0, 6'b000_000, 0, 0);
    #1;
    chk_all("reset_state");
    tick("rst0"); tick("rst1");
    rst = 1'b1;

    // Rate 1/2, then same pair with unused bits set.
    drive(1, 0, 6'b000_011, 1, 0); tick("r2_a0");
    chk("r2_lat1.valid", 16'(o_valid), 16'd0);
    drive(1, 0, 6'b100_111, 1, 0); tick("r2_a1");
    chk("r2.bm0", bm_0, 16'h0016); chk("r2.bm1", bm_1, 16'h0094);
    chk("r2.valid", 16'(o_valid), 16'd1);
    drive(1, 1, 6'b000_101, 1, 0); tick("r2_b");
    chk("r2u.bm0", bm_0, 16'h0016); chk("r2u.bm1", bm_1, 16'h0094);
    drive(1, 0, 6'b000_000, 0, 0); tick("r3_a");
    chk("r3.bm0", bm_0, 16'h61B6); chk("r3.bm1", bm_1, 16'hE994);
    tick("idle");

    // Alternating rates with random symbols.
    for (int i = 0; i < 12; i++) begin
      drive(1, 1'(i), 6'($urandom), 1, 0); tick("alt");
    end

    // Reset mid-traffic, then 20 back-to-back pairs.
    do_reset();
    drive(1, 1'($urandom), 6'($urandom), 1, 0); tick("blk_fill");
    for (int i = 1; i <= 20; i++) begin
      drive(1, 1'($urandom), 6'($urandom), (i < 20), 0); tick("blk");
      chk("blk.cnt",  16'(pair_cnt), 16'(i % 8));
      chk("blk.done", 16'(blk_done), 16'(i % 8 == 0));
    end
    tick("blk_tail");

    // Flush on the 3rd pair with a 2-cycle stall inside the stream.
    do_reset();
    seen_valid = 0; seen_done = 0;
    drive(1, 0, 6'($urandom), 1, 0); tick("fl1");
    drive(1, 1, 6'($urandom), 1, 0); tick("fl2");
    drive(0, 0, 6'($urandom), 1, 0); tick("stall1");
    drive(0, 1, 6'($urandom), 0, 1); tick("stall2");
    drive(1, 0, 6'($urandom), 1, 1); tick("fl3");
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'($urandom), 6'($urandom), 1, 0); tick("fl_after");
    end
    chk("flush.valids", 16'(seen_valid), 16'd3);
    chk("flush.dones",  16'(seen_done), 16'd1);
    chk("flush.ood",    16'(o_ood), 16'd1);

    // ood with no pending pairs.
    do_reset();
    drive(1, 0, 6'd0, 0, 1); tick("ood0_a");
    drive(1, 0, 6'd0, 0, 0); tick("ood0_b");
    chk("ood0.ood",  16'(o_ood), 16'd1);
    chk("ood0.done", 16'(blk_done), 16'd0);

    // Random segments.
    for (int s = 0; s < 5; s++) begin
      do_reset();
      for (int i = 0; i < 80; i++) begin
        drive(($urandom_range(0, 9) != 0), 1'($urandom), 6'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
        tick("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_metric.md
# branch_metric

Radix-4 hard-decision branch metric unit for the Viterbi decoder datapath. It sits directly downstream of the input slicer and consumes two received symbols per cycle: symbol 0 on `i_rx[2:0]` and symbol 1 on `i_rx[5:3]`. For each symbol it computes the Hamming distance to every possible expected codeword, for code rate 1/2 or 1/3. It counts symbol pairs into traceback blocks, aligns the slicer's end-of-data flag with its own output, and feeds the add-compare-select stage.

## Interface
- `BLK_PAIRS`, default 8: number of valid symbol pairs per traceback block (range 1..255).
- `rst`  in  1  asynchronous reset, active low.
- `clk`  in  1  clock, rising edge.
- `en_bm`  in  1  stage enable; low freezes the whole pipeline (all registers hold).
- `i_code_rate`  in  1  `CODE_RATE_2` (0) = rate 1/2, `CODE_RATE_3` (1) = rate 1/3; sampled per pair.
- `i_rx`  in  `SLICED_INPUT_NUM` (6)  two received symbols: sym0 = `[2:0]`, sym1 = `[5:3]`.
- `i_valid`  in  1  `i_rx` holds a real pair this cycle (slicer output qualifier).
- `i_ood`  in  1  slicer end-of-data flag; coincides with the last valid pair or arrives after it.
- `o_bm_0`  out  16  sym0 distances; entry c (codeword c, 0..7) at `[2c+1:2c]`.
- `o_bm_1`  out  16  sym1 distances, same packing.
- `o_valid`  out  1  `o_bm_0`/`o_bm_1` are valid.
- `o_blk_done`  out  1  one-cycle pulse with the last pair of a block (full or flushed).
- `o_pair_cnt`  out  8  valid pairs emitted so far in the current block.
- `o_ood`  out  1  `i_ood` delayed to align with the outputs.

## Operation
- Distance: d(sym, c) = popcount((sym XOR c) & mask).
  - Rate 1/2: mask = 3'b011, c in 0..3; entries 4..7 are forced to 0.
  - Rate 1/3: mask = 3'b111, c in 0..7.
- Each entry is 2 bits; the maximum value is 3, so there is no overflow.
- Two-stage pipeline:
  - S1 registers `i_rx`, `i_code_rate`, `i_valid`, `i_ood`.
  - S2 computes the distances from the S1 registers and registers all outputs.
- While the S1 valid bit is 0, S2 loads `o_bm_0` = `o_bm_1` = 0 and `o_valid` = 0.
- Pair counter (drives `o_pair_cnt`):
  - On each S2 load with valid = 1, the counter increments.
  - If the new count equals `BLK_PAIRS`, `o_blk_done` = 1 and the counter loads 0.
- Flush: when the S1 ood bit is 1 and the counter would be nonzero after this cycle, `o_blk_done` pulses and the counter loads 0. A partial block is closed this way.
- No double pulse: if the block fills on the same cycle ood is seen, `o_blk_done` pulses once.
- `o_ood` is sticky: once set, it stays 1 until reset.
- After `o_ood` is set, further `i_valid` pairs are ignored (`o_valid` stays 0).
- Rate changes between pairs are legal. Each pair uses its own sampled rate, and the counter is unaffected.

## Timing
- Reset (async, `rst` = 0): all S1/S2 registers, `o_bm_0`, `o_bm_1`, `o_valid`, `o_blk_done`, `o_pair_cnt`, `o_ood` go to 0 immediately.
- Latency: a pair presented with `i_valid` at edge N (and `en_bm` = 1 at N and N+1) appears with `o_valid` = 1 after edge N+1. `i_ood` follows the same 2-edge path.
- Throughput: one pair per cycle, with no back-pressure.
- `o_blk_done` and `o_ood` are asserted in the same cycle as the `o_valid` they relate to.
- `en_bm` = 0: no register updates, and outputs hold their previous values, including `o_valid` and `o_blk_done`. A pulse therefore stretches across a stall; downstream must qualify with its own enable.
- Reset mid-block: the counter returns to 0 and the partial block is discarded without an `o_blk_done` pulse.
- `i_ood` with `i_valid` = 0 and counter = 0: `o_ood` rises, no `o_blk_done` pulse.

## Test plan
- Reset state: hold `rst` = 0 mid-run with traffic → all outputs 0 within the same cycle. After release, the first `o_valid` appears exactly 2 edges after the first `i_valid`.
- Rate 1/2: `i_rx` = 6'b000_011, rate 0 → `o_bm_0` = 16'h0016, `o_bm_1` = 16'h0094, `o_valid` = 1 at N+2. Also set `i_rx[2]` and `i_rx[5]` to 1 → outputs unchanged (unused bits ignored).
- Rate 1/3: `i_rx` = 6'b000_101, rate 1 → `o_bm_0` = 16'h61B6, `o_bm_1` = 16'hE994. Alternate rate 0/1 on consecutive cycles → each output matches its own pair's rate.
- Block counting: `BLK_PAIRS` = 8, 20 consecutive valid pairs → `o_blk_done` pulses on output pairs 8 and 16. `o_pair_cnt` runs 1..7, 0, 1..7, 0, 1..4.
- Flush and stall: 3 pairs, then `i_ood` with the 3rd pair → one `o_blk_done` on the 3rd output, `o_ood` = 1 sticky, later pairs ignored. Repeat with `en_bm` = 0 for 2 cycles mid-stream → outputs frozen, and the stream resumes with no pair lost or duplicated.
